vault_door_ctrl: RTL and testbench

Downstream of the vault puzzle top level: consumes the `all_done` level and the OR of the five phase-fail pulses, then drives the physical door motor through a request/acknowledge handshake. Counts failed attempts and enforces a timed lockout after too many failures. After every open/close cycle or lockout it issues a one-cycle `vault_reset` pulse so the puzzle restarts.

---
 rtl/vault_door_pkg.sv | 34 +++
 rtl/door_timer.sv | 31 +++
 rtl/vault_door_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vault_door_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vault_door_pkg.sv
// Shared definitions for the vault door controller: state encodings and
// timer sizing helpers.
package vault_door_pkg;

  // Encoded FSM states (plain constants so legacy tools and waveforms agree)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  // Typed view of the same encodings, handy for casting in debug code
  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_OPENING = ST_OPENING,
    S_OPEN    = ST_OPEN,
    S_CLOSING = ST_CLOSING,
    S_LOCKOUT = ST_LOCKOUT,
    S_FAULT   = ST_FAULT
  } door_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the largest reload value (cycles - 1), at least 1
  function automatic int timer_width(input int max_cycles);
    return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter shared by all timed states of the door controller.
// expired is high while the count sits at zero; the count never wraps.
module door_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values, independent of statement order.
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/vault_door_ctrl.sv
// Vault door controller: opens the door when the puzzle is solved, closes
// it after a hold period, counts failed attempts and enforces a lockout.
// Optional motor-timeout/alarm support is built when VAULT_DOOR_ALARM_EN
// is defined; without it OPENING/CLOSING wait for the motor indefinitely.
module vault_door_ctrl
  import vault_door_pkg::*;
#(
  parameter int MAX_FAILS        = 3,
  parameter int LOCKOUT_CYCLES   = 64,
  parameter int OPEN_HOLD_CYCLES = 32,
  parameter int MOTOR_TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           all_done,
  input  logic                           phase_fail,
  input  logic                           door_closed,
  input  logic                           motor_ack,
  output logic                           motor_open_req,
  output logic                           motor_close_req,
  output logic                           door_unlocked,
  output logic                           lockout,
  output logic                           alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic                           vault_reset
);

  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = timer_width(max3(MOTOR_TIMEOUT, OPEN_HOLD_CYCLES, LOCKOUT_CYCLES));

  // Timer reloads are cycles-1 so each timed state lasts exactly N cycles
  localparam logic [TW-1:0] LD_MOTOR = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(OPEN_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LD_LOCK  = TW'(LOCKOUT_CYCLES - 1);

  localparam logic [FCW-1:0] FC_MAX  = FCW'(MAX_FAILS);
  localparam logic [FCW-1:0] FC_LAST = FCW'(MAX_FAILS - 1);

  logic [2:0]     r_state;
  logic           r_all_done_q;
  logic [FCW-1:0] r_fail_count;
  logic           r_vault_reset_evt;

  logic [2:0]     w_state_nxt;
  logic           w_rise;
  logic           w_load;
  logic [TW-1:0]  w_load_val;
  logic           w_expired;
  logic           w_fail_inc;
  logic           w_fail_clr;
  logic           w_vr_evt;

  assign w_rise = all_done & ~r_all_done_q;

  door_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (r_state != ST_IDLE),
    .expired  (w_expired)
  );

  // Next-state, timer reload and fail-counter control
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = LD_MOTOR;
    w_fail_inc  = 1'b0;
    w_fail_clr  = 1'b0;
    w_vr_evt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          // A rise in the same cycle as a fail wins; the fail is dropped
          w_state_nxt = ST_OPENING;
          w_load      = 1'b1;
          w_load_val  = LD_MOTOR;
        end else if (phase_fail && (r_fail_count != FC_MAX)) begin
          w_fail_inc = 1'b1;
          if (r_fail_count == FC_LAST) begin
            w_state_nxt = ST_LOCKOUT;
            w_load      = 1'b1;
            w_load_val  = LD_LOCK;
          end
        end
      end
      ST_OPENING: begin
        // Ack on the expiry cycle still counts as success
        if (motor_ack) begin
          w_state_nxt = ST_OPEN;
          w_load      = 1'b1;
          w_load_val  = LD_HOLD;
          w_fail_clr  = 1'b1;
        end
`ifdef VAULT_DOOR_ALARM_EN
        else if (w_expired) begin
          w_state_nxt = ST_FAULT;
        end
`endif
      end
      ST_OPEN: begin
        if (w_expired && door_closed) begin
          w_state_nxt = ST_CLOSING;
          w_load      = 1'b1;
          w_load_val  = LD_MOTOR;
        end
      end
      ST_CLOSING: begin
        if (motor_ack) begin
          w_state_nxt = ST_IDLE;
          w_vr_evt    = 1'b1;
        end
`ifdef VAULT_DOOR_ALARM_EN
        else if (w_expired) begin
          w_state_nxt = ST_FAULT;
        end
`endif
      end
      ST_LOCKOUT: begin
        if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_fail_clr  = 1'b1;
          w_vr_evt    = 1'b1;
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, edge-detect copy, fail counter and restart event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_all_done_q      <= 1'b0;
      r_fail_count      <= '0;
      r_vault_reset_evt <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_all_done_q      <= all_done;
      r_vault_reset_evt <= w_vr_evt;
      if (w_fail_clr) begin
        r_fail_count <= '0;
      end else if (w_fail_inc) begin
        r_fail_count <= r_fail_count + FCW'(1);
      end
    end
  end

  // Registered output decode; the async reset drops motor requests at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_open_req  <= 1'b0;
      motor_close_req <= 1'b0;
      door_unlocked   <= 1'b0;
      lockout         <= 1'b0;
      vault_reset     <= 1'b0;
    end else begin
      motor_open_req  <= (r_state == ST_OPENING);
      motor_close_req <= (r_state == ST_CLOSING);
      door_unlocked   <= (r_state == ST_OPEN);
      lockout         <= (r_state == ST_LOCKOUT);
      vault_reset     <= r_vault_reset_evt;
    end
  end

`ifdef VAULT_DOOR_ALARM_EN
  // Alarm follows the latched FAULT state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else begin
      alarm <= (r_state == ST_FAULT);
    end
  end
`else
  assign alarm = 1'b0;
`endif

  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_vault_door_ctrl.sv
// Self-checking bench for vault_door_ctrl. Expected values are queued when
// stimulus is applied and popped when the matching DUT output is observed.
module tb_vault_door_ctrl;

  localparam int MF = 3;
  localparam int LC = 64;
  localparam int OH = 32;
  localparam int MT = 16;

  logic       clk;
  logic       reset;
  logic       all_done;
  logic       phase_fail;
  logic       door_closed;
  logic       motor_ack;
  logic       motor_open_req;
  logic       motor_close_req;
  logic       door_unlocked;
  logic       lockout;
  logic       alarm;
  logic [1:0] fail_count;
  logic       vault_reset;

  vault_door_ctrl #(
    .MAX_FAILS        (MF),
    .LOCKOUT_CYCLES   (LC),
    .OPEN_HOLD_CYCLES (OH),
    .MOTOR_TIMEOUT    (MT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .all_done        (all_done),
    .phase_fail      (phase_fail),
    .door_closed     (door_closed),
    .motor_ack       (motor_ack),
    .motor_open_req  (motor_open_req),
    .motor_close_req (motor_close_req),
    .door_unlocked   (door_unlocked),
    .lockout         (lockout),
    .alarm           (alarm),
    .fail_count      (fail_count),
    .vault_reset     (vault_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input int got);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return motor_open_req;
      1:       return motor_close_req;
      2:       return door_unlocked;
      3:       return lockout;
      4:       return alarm;
      default: return vault_reset;
    endcase
  endfunction

  // Step until the selected output reaches level; bounded by limit
  task automatic steps_until(input int sel, input logic level, input int limit, output int n);
    n = 0;
    while ((get_out(sel) !== level) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  // Pulse motor_ack for one edge and check the restart pulse after closing
  task automatic ack_close();
    motor_ack = 1'b1;
    step();
    motor_ack = 1'b0;
    expect_val("close_req_held_at_ack", 1);
    compare(motor_close_req);
    step();
    expect_val("close_req_dropped", 0);
    compare(motor_close_req);
    expect_val("vault_reset_after_close", 1);
    compare(vault_reset);
    step();
    expect_val("vault_reset_one_cycle", 0);
    compare(vault_reset);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset       = 1'b1;
    all_done    = 1'b0;
    phase_fail  = 1'b0;
    door_closed = 1'b1;
    motor_ack   = 1'b0;
    repeat (3) step();

    // Reset state
    expect_val("rst_open_req", 0);   compare(motor_open_req);
    expect_val("rst_close_req", 0);  compare(motor_close_req);
    expect_val("rst_unlocked", 0);   compare(door_unlocked);
    expect_val("rst_lockout", 0);    compare(lockout);
    expect_val("rst_alarm", 0);      compare(alarm);
    expect_val("rst_fail_count", 0); compare(fail_count);
    expect_val("rst_vault_reset", 0); compare(vault_reset);
    reset = 1'b0;
    step();

    // Stray ack with no request is ignored
    motor_ack = 1'b1;
    step();
    motor_ack = 1'b0;
    step();
    expect_val("stray_ack_unlocked", 0); compare(door_unlocked);
    expect_val("stray_ack_open_req", 0); compare(motor_open_req);

    // Open/close cycle
    all_done = 1'b1;
    expect_val("open_req_latency", 2);
    steps_until(0, 1'b1, 20, n);
    compare(n);
    repeat (3) step();
    motor_ack = 1'b1;
    step();
    motor_ack = 1'b0;
    expect_val("open_req_held_at_ack", 1); compare(motor_open_req);
    step();
    expect_val("open_req_dropped", 0);  compare(motor_open_req);
    expect_val("unlocked_after_ack", 1); compare(door_unlocked);
    expect_val("hold_length", OH);
    steps_until(2, 1'b0, OH + 10, n);
    compare(n);
    expect_val("close_req_after_hold", 1); compare(motor_close_req);
    all_done = 1'b0;
    ack_close();

    // Lockout after MAX_FAILS failures
    for (int k = 1; k <= MF; k++) begin
      phase_fail = 1'b1;
      step();
      phase_fail = 1'b0;
      expect_val($sformatf("fail_count_%0d", k), k);
      compare(fail_count);
      if (k < MF) step();
    end
    step();
    expect_val("lockout_entered", 1); compare(lockout);
    all_done = 1'b1;
    expect_val("lockout_length", LC);
    steps_until(3, 1'b0, LC + 10, n);
    compare(n);
    expect_val("vault_reset_after_lockout", 1); compare(vault_reset);
    expect_val("fail_count_cleared", 0);       compare(fail_count);
    repeat (3) step();
    expect_val("all_done_ignored_in_lockout", 0); compare(motor_open_req);
    all_done = 1'b0;
    step();

    // Simultaneous fail and all_done rise with fail_count = MF-1
    for (int k = 0; k < MF - 1; k++) begin
      phase_fail = 1'b1;
      step();
      phase_fail = 1'b0;
      step();
    end
    expect_val("fail_count_before_race", MF - 1); compare(fail_count);
    all_done   = 1'b1;
    phase_fail = 1'b1;
    step();
    phase_fail = 1'b0;
    expect_val("fail_dropped_on_rise", MF - 1); compare(fail_count);
    expect_val("race_open_req_latency", 1);
    steps_until(0, 1'b1, 20, n);
    compare(n);
    expect_val("race_no_lockout", 0); compare(lockout);
    motor_ack = 1'b1;
    step();
    motor_ack = 1'b0;
    step();
    expect_val("fail_count_cleared_on_ack", 0); compare(fail_count);

    // Door held open past the hold period
    door_closed = 1'b0;
    repeat (OH + 8) step();
    expect_val("held_open_unlocked", 1);  compare(door_unlocked);
    expect_val("held_open_no_close", 0);  compare(motor_close_req);
    door_closed = 1'b1;
    expect_val("close_after_door_shut", 2);
    steps_until(1, 1'b1, 20, n);
    compare(n);
    all_done = 1'b0;
    ack_close();

    // Motor timeout
    all_done = 1'b1;
    expect_val("timeout_open_req_latency", 2);
    steps_until(0, 1'b1, 20, n);
    compare(n);
`ifdef VAULT_DOOR_ALARM_EN
    expect_val("timeout_req_length", MT);
    steps_until(0, 1'b0, MT + 10, n);
    compare(n);
    expect_val("fault_alarm", 1);     compare(alarm);
    expect_val("fault_close_req", 0); compare(motor_close_req);
    repeat (5) step();
    expect_val("fault_sticky", 1);    compare(alarm);
`else
    repeat (MT + 20) step();
    expect_val("no_timeout_req_held", 1); compare(motor_open_req);
    expect_val("no_timeout_alarm", 0);    compare(alarm);
`endif
    reset = 1'b1;
    #1;
    expect_val("reset_open_req", 0); compare(motor_open_req);
    expect_val("reset_alarm", 0);    compare(alarm);
    expect_val("reset_unlocked", 0); compare(door_unlocked);
    all_done = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Mid-operation reset during OPENING, then a fresh start
    all_done = 1'b1;
    expect_val("pre_reset_open_latency", 2);
    steps_until(0, 1'b1, 20, n);
    compare(n);
    #2;
    reset = 1'b1;
    #1;
    expect_val("async_reset_drops_req", 0); compare(motor_open_req);
    all_done = 1'b0;
    step();
    reset = 1'b0;
    step();
    all_done = 1'b1;
    expect_val("restart_open_latency", 2);
    steps_until(0, 1'b1, 20, n);
    compare(n);
    expect_val("restart_fail_count", 0); compare(fail_count);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
